// File: rtl/i2c_txn_scheduler.sv
// rtl/i2c_txn_scheduler.sv - round-robin scheduler sharing one I2C controller
// between N_REQ requesters, with start timeout and arbitration-loss retry.
module i2c_txn_scheduler #(
   parameter int N_REQ             = 3,
   parameter int BYTES_SEND_LOG    = 2,
   parameter int BYTES_RECEIVE_LOG = 2,
   parameter int BITS_SEND_MAX     = ((2**BYTES_SEND_LOG) - 1) << 3,
   parameter int MAX_RETRY         = 3,
   parameter int START_TIMEOUT     = 1023,
   parameter int RETRY_GAP         = 64,
   localparam int ID_W             = $clog2(N_REQ)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [N_REQ-1:0]                     req,
   input  logic [8*N_REQ-1:0]                   req_addr,
   input  logic [BITS_SEND_MAX*N_REQ-1:0]       req_data,
   input  logic [BYTES_SEND_LOG*N_REQ-1:0]      req_nsend,
   input  logic [BYTES_RECEIVE_LOG*N_REQ-1:0]   req_nrecv,
   output logic [N_REQ-1:0]                     gnt,
   output logic [N_REQ-1:0]                     done,
   output logic [N_REQ-1:0]                     err,
   output logic                                 ctrl_start,
   output logic [7:0]                           ctrl_addr,
   output logic [BITS_SEND_MAX-1:0]             ctrl_data,
   output logic [BYTES_SEND_LOG-1:0]            ctrl_nsend,
   output logic [BYTES_RECEIVE_LOG-1:0]         ctrl_nrecv,
   input  logic                                 ctrl_busy,
   input  logic                                 ctrl_arb_lost,
   output logic                                 sched_busy,
   output logic [ID_W-1:0]                      cur_id
);

   localparam int TMR_W = $clog2(START_TIMEOUT + 1);
   localparam int GAP_W = $clog2(RETRY_GAP + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRY_GAP - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_WAIT_BUSY, S_RUN, S_BACKOFF
   } state_t;

   state_t                state, state_nxt;
   logic [ID_W-1:0]       ptr, win_id;
   logic                  win_found, latch;
   logic [TMR_W-1:0]      timer, timer_nxt;
   logic [GAP_W-1:0]      gap, gap_nxt;
   logic [RTY_W-1:0]      retry, retry_nxt;
   logic [N_REQ-1:0]      gnt_nxt, done_nxt, err_nxt;

   logic [7:0]                   addr_arr  [N_REQ];
   logic [BITS_SEND_MAX-1:0]     data_arr  [N_REQ];
   logic [BYTES_SEND_LOG-1:0]    nsend_arr [N_REQ];
   logic [BYTES_RECEIVE_LOG-1:0] nrecv_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*8 +: 8];
      assign data_arr[g]  = req_data[g*BITS_SEND_MAX +: BITS_SEND_MAX];
      assign nsend_arr[g] = req_nsend[g*BYTES_SEND_LOG +: BYTES_SEND_LOG];
      assign nrecv_arr[g] = req_nrecv[g*BYTES_RECEIVE_LOG +: BYTES_RECEIVE_LOG];
   end

   // Two passes: requesters at or above the pointer first, then the wrapped ones.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && req[i] && (ID_W'(i) >= ptr)) begin
            win_found = 1'b1;
            win_id    = ID_W'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!win_found && req[i]) begin
            win_found = 1'b1;
            win_id    = ID_W'(i);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      gap_nxt   = gap;
      retry_nxt = retry;
      gnt_nxt   = '0;
      done_nxt  = '0;
      err_nxt   = '0;
      latch     = 1'b0;
      case (state)
         S_IDLE: begin
            if (win_found) begin
               latch     = 1'b1;
               gnt_nxt   = N_REQ'(1) << win_id;
               retry_nxt = '0;
               state_nxt = S_START;
            end
         end
         S_START: begin
            timer_nxt = '0;
            state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (ctrl_busy) begin
               state_nxt = S_RUN;
            end else if (timer == TMR_LAST) begin
               err_nxt   = N_REQ'(1) << cur_id;
               state_nxt = S_IDLE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_RUN: begin
            // Arbitration loss takes priority over a simultaneous busy fall.
            if (ctrl_arb_lost) begin
               if (retry == RTY_MAX) begin
                  err_nxt   = N_REQ'(1) << cur_id;
                  state_nxt = S_IDLE;
               end else begin
                  retry_nxt = retry + 1'b1;
                  gap_nxt   = '0;
                  state_nxt = S_BACKOFF;
               end
            end else if (!ctrl_busy) begin
               done_nxt  = N_REQ'(1) << cur_id;
               state_nxt = S_IDLE;
            end
         end
         S_BACKOFF: begin
            // The gap is measured from bus release, so it restarts while busy.
            if (ctrl_busy) begin
               gap_nxt = '0;
            end else if (gap == GAP_LAST) begin
               state_nxt = S_START;
            end else begin
               gap_nxt = gap + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         ptr        <= '0;
         timer      <= '0;
         gap        <= '0;
         retry      <= '0;
         gnt        <= '0;
         done       <= '0;
         err        <= '0;
         cur_id     <= '0;
         ctrl_addr  <= '0;
         ctrl_data  <= '0;
         ctrl_nsend <= '0;
         ctrl_nrecv <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         gap   <= gap_nxt;
         retry <= retry_nxt;
         gnt   <= gnt_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
         if (latch) begin
            cur_id     <= win_id;
            ptr        <= (win_id == ID_LAST) ? '0 : win_id + 1'b1;
            ctrl_addr  <= addr_arr[win_id];
            ctrl_data  <= data_arr[win_id];
            ctrl_nsend <= nsend_arr[win_id];
            ctrl_nrecv <= nrecv_arr[win_id];
         end
      end
   end

   assign ctrl_start = (state == S_START);
   assign sched_busy = (state != S_IDLE);

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// tb/tb_i2c_txn_scheduler.sv - directed bench for i2c_txn_scheduler.
module tb_i2c_txn_scheduler;
   localparam int N  = 3;
   localparam int SL = 2;
   localparam int RL = 2;
   localparam int BW = 24;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]    req = '0;
   logic [8*N-1:0]  req_addr = '0;
   logic [BW*N-1:0] req_data = '0;
   logic [SL*N-1:0] req_nsend = '0;
   logic [RL*N-1:0] req_nrecv = '0;
   logic [N-1:0]    gnt, done, err;
   logic            ctrl_start;
   logic [7:0]      ctrl_addr;
   logic [BW-1:0]   ctrl_data;
   logic [SL-1:0]   ctrl_nsend;
   logic [RL-1:0]   ctrl_nrecv;
   logic            ctrl_busy = 1'b0;
   logic            ctrl_arb_lost = 1'b0;
   logic            sched_busy;
   logic [IW-1:0]   cur_id;

   i2c_txn_scheduler dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
      .req_nsend(req_nsend), .req_nrecv(req_nrecv), .gnt(gnt), .done(done), .err(err),
      .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr), .ctrl_data(ctrl_data),
      .ctrl_nsend(ctrl_nsend), .ctrl_nrecv(ctrl_nrecv), .ctrl_busy(ctrl_busy),
      .ctrl_arb_lost(ctrl_arb_lost), .sched_busy(sched_busy), .cur_id(cur_id)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_start = 0;
   int n_done [N] = '{default: 0};
   int n_err  [N] = '{default: 0};
   int oh_bad = 0, ovl = 0, long_bad = 0;
   logic [N-1:0] pg = '0, pd = '0, pe = '0;

   always @(negedge clk) begin
      if (ctrl_start === 1'b1) n_start++;
      for (int i = 0; i < N; i++) begin
         if (done[i] === 1'b1) n_done[i]++;
         if (err[i] === 1'b1) n_err[i]++;
      end
      if ($countones(gnt) > 1 || $countones(done) > 1 || $countones(err) > 1) oh_bad++;
      if ($countones({|gnt, |done, |err}) > 1) ovl++;
      if ((gnt & pg) != 0 || (done & pd) != 0 || (err & pe) != 0) long_bad++;
      pg = gnt;
      pd = done;
      pe = err;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_start(input int lim, output int c);
      c = -1;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (ctrl_start === 1'b1) begin
            c = cyc;
            break;
         end
      end
      if (c < 0) check("start_wait_expired", 0, 1);
   endtask

   task automatic set_desc(input int id, input logic [7:0] a, input logic [BW-1:0] d,
                           input logic [SL-1:0] ns, input logic [RL-1:0] nr);
      req_addr[id*8 +: 8]    = a;
      req_data[id*BW +: BW]  = d;
      req_nsend[id*SL +: SL] = ns;
      req_nrecv[id*RL +: RL] = nr;
   endtask

   // Called on the negedge where ctrl_start is seen; runs a clean transaction.
   task automatic finish_txn(input int id);
      tick();
      ctrl_busy = 1'b1;
      tick(2);
      ctrl_busy = 1'b0;
      tick();
      check("finish_done", done, 32'(1) << id);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      tick(2);
      rst = 1'b1;
   endtask

   int s, s2, e, fall, n0, d0, e0, sum0, sum1;

   initial begin
      // reset state
      tick(2);
      check("rst_gnt", gnt, 0);
      check("rst_done_err", {done, err}, 0);
      check("rst_start_busy", {ctrl_start, sched_busy}, 0);
      check("rst_addr_data", {ctrl_addr, ctrl_data}, 0);
      check("rst_cnt_id", {ctrl_nsend, ctrl_nrecv, cur_id}, 0);
      rst = 1'b1;
      tick(2);

      // single request
      set_desc(1, 8'h8F, 24'hA5C300, 2'd2, 2'd1);
      req = 3'b010;
      tick();
      check("single_gnt", gnt, 3'b010);
      check("single_start", ctrl_start, 1);
      check("single_addr", ctrl_addr, 8'h8F);
      check("single_data", ctrl_data, 24'hA5C300);
      check("single_counts", {ctrl_nsend, ctrl_nrecv}, 4'b1001);
      check("single_id", cur_id, 1);
      req = 3'b000;
      tick();
      check("single_start_1cyc", {ctrl_start, gnt}, 0);
      tick(2);
      ctrl_busy = 1'b1;
      tick(200);
      check("single_no_done_yet", done, 0);
      ctrl_busy = 1'b0;
      tick();
      check("single_done", done, 3'b010);
      tick();
      check("single_idle", {done, sched_busy}, 0);

      // round-robin
      do_reset();
      tick();
      req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         wait_start(5, s);
         check("rr_gnt", gnt, 32'(1) << (k % 3));
         if (k == 3) req = 3'b000;
         finish_txn(k % 3);
      end
      tick(2);

      // arbitration loss with backoff
      #1 d0 = n_done[1];
      e0 = n_err[1];
      set_desc(1, 8'h3C, 24'h123456, 2'd3, 2'd2);
      req = 3'b010;
      wait_start(5, s);
      req = 3'b000;
      check("arb_gnt", gnt, 3'b010);
      tick();
      ctrl_busy = 1'b1;
      tick();
      ctrl_arb_lost = 1'b1;
      tick();
      ctrl_arb_lost = 1'b0;
      tick(4);
      ctrl_busy = 1'b0;
      fall = cyc;
      wait_start(100, s2);
      check("arb_gap", s2 - fall, 64);
      check("arb_no_regrant", gnt, 0);
      check("arb_desc", {ctrl_addr, ctrl_data}, {8'h3C, 24'h123456});
      check("arb_desc_cnt", {ctrl_nsend, ctrl_nrecv, cur_id}, {2'd3, 2'd2, 2'd1});
      finish_txn(1);
      tick(2);
      #1 check("arb_single_done", n_done[1] - d0, 1);
      check("arb_no_err", n_err[1] - e0, 0);

      // retry exhaustion
      #1 n0 = n_start;
      d0 = n_done[2];
      set_desc(2, 8'h55, 24'hDEADBE, 2'd1, 2'd3);
      req = 3'b100;
      for (int l = 0; l < 4; l++) begin
         wait_start((l == 0) ? 5 : 200, s);
         if (l == 0) req = 3'b000;
         tick();
         ctrl_busy = 1'b1;
         tick();
         ctrl_arb_lost = 1'b1;
         tick();
         ctrl_arb_lost = 1'b0;
         ctrl_busy = 1'b0;
         if (l == 3) begin
            check("exh_err", err, 3'b100);
            check("exh_idle", sched_busy, 0);
         end else begin
            check("exh_err_early", err, 0);
         end
      end
      tick(3);
      #1 check("exh_starts", n_start - n0, 4);
      check("exh_no_done", n_done[2] - d0, 0);

      // start timeout, then pending request is served
      #1 d0 = n_done[0];
      req = 3'b001;
      wait_start(5, s);
      check("tmo_gnt", gnt, 3'b001);
      req = 3'b010;
      e = -1;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if (err !== 3'b000) begin
            e = cyc;
            break;
         end
      end
      check("tmo_latency", e - s, 1024);
      check("tmo_err", err, 3'b001);
      wait_start(5, s2);
      check("tmo_next_gnt", gnt, 3'b010);
      check("tmo_next_when", s2 - e, 1);
      req = 3'b000;
      finish_txn(1);
      tick();
      #1 check("tmo_no_done", n_done[0] - d0, 0);

      // reset during RUN
      req = 3'b010;
      wait_start(5, s);
      req = 3'b000;
      tick();
      ctrl_busy = 1'b1;
      tick(2);
      #1 sum0 = n_done[0] + n_done[1] + n_done[2] + n_err[0] + n_err[1] + n_err[2];
      #1 rst = 1'b0;
      #1;
      check("mid_rst_pulses", {gnt, done, err}, 0);
      check("mid_rst_flags", {ctrl_start, sched_busy, cur_id}, 0);
      check("mid_rst_desc", {ctrl_addr, ctrl_data}, 0);
      check("mid_rst_cnt", {ctrl_nsend, ctrl_nrecv}, 0);
      ctrl_busy = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(2);
      #1 sum1 = n_done[0] + n_done[1] + n_done[2] + n_err[0] + n_err[1] + n_err[2];
      check("mid_rst_no_pulse", sum1 - sum0, 0);
      req = 3'b110;
      wait_start(5, s);
      check("post_rst_ptr", gnt, 3'b010);
      req = 3'b000;
      finish_txn(1);
      req = 3'b100;
      wait_start(5, s);
      check("post_rst_gnt2", gnt, 3'b100);
      req = 3'b000;
      finish_txn(2);
      tick(2);

      #1 check("onehot", oh_bad, 0);
      check("overlap", ovl, 0);
      check("pulse_width", long_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1);
   end

endmodule
